// File: rtl/change_dispenser.sv
// Vend motor / nickel ejector sequencer with hopper inventory, one-deep request buffer and latched faults.
// Optional `DISPENSE_LOG_EN adds a 16-bit sales_count output.
module change_dispenser #(
    parameter int VEND_CYCLES  = 4,
    parameter int EJECT_CYCLES = 2,
    parameter int ACK_TIMEOUT  = 8,
    parameter int HOPPER_INIT  = 16,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dispense,
    input  logic [1:0]       change,
    input  logic             coin_seen,
    input  logic             refill,
    output logic             vend_motor,
    output logic             eject,
    output logic             busy,
    output logic             fault,
    output logic             pending_ovf,
    output logic [CNT_W-1:0] hopper_level,
`ifdef DISPENSE_LOG_EN
    output logic [15:0]      sales_count,
`endif
    output logic [2:0]       state_dbg_o
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] VEND     = 3'd1;
    localparam logic [2:0] EJECT    = 3'd2;
    localparam logic [2:0] WAIT_ACK = 3'd3;
    localparam logic [2:0] FAULT    = 3'd4;

    localparam int TMR_MAX0 = (VEND_CYCLES > EJECT_CYCLES) ? VEND_CYCLES : EJECT_CYCLES;
    localparam int TMR_MAX  = (TMR_MAX0 > ACK_TIMEOUT) ? TMR_MAX0 : ACK_TIMEOUT;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] T_VEND  = TMR_W'(VEND_CYCLES);
    localparam logic [TMR_W-1:0] T_EJECT = TMR_W'(EJECT_CYCLES);
    localparam logic [TMR_W-1:0] T_ACK   = TMR_W'(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0] T_ONE   = TMR_W'(1);
    localparam logic [CNT_W-1:0] H_INIT  = CNT_W'(HOPPER_INIT);
    localparam logic [CNT_W-1:0] H_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_ZERO  = '0;

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       remaining_q, remaining_d;
    logic             pend_valid_q, pend_valid_d;
    logic [1:0]       pend_code_q, pend_code_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] hopper_q, hopper_d;
    logic             complete, consume, take_direct;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        remaining_d  = remaining_q;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        ovf_d        = ovf_q;
        hopper_d     = refill ? H_INIT : hopper_q;
        complete     = 1'b0;
        consume      = 1'b0;
        take_direct  = 1'b0;

        case (state_q)
            IDLE: begin
                // A request buffered during the final busy cycle is launched from here.
                if (pend_valid_q) begin
                    complete = 1'b1;
                end else if (dispense) begin
                    take_direct = 1'b1;
                    state_d     = VEND;
                    remaining_d = change;
                    timer_d     = T_VEND;
                end
            end
            VEND: begin
                if (timer_q == T_ONE) begin
                    if (remaining_q == 2'd0) begin
                        complete = 1'b1;
                    end else if (hopper_d == H_ZERO) begin
                        state_d = FAULT;
                    end else begin
                        state_d = EJECT;
                        timer_d = T_EJECT;
                    end
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            EJECT: begin
                if (timer_q == T_ONE) begin
                    state_d = WAIT_ACK;
                    timer_d = T_ACK;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            WAIT_ACK: begin
                if (coin_seen) begin
                    remaining_d = remaining_q - 2'd1;
                    if (!refill && hopper_q != H_ZERO) hopper_d = hopper_q - H_ONE;
                    if (remaining_d == 2'd0) begin
                        complete = 1'b1;
                    end else if (hopper_d == H_ZERO) begin
                        state_d = FAULT;
                    end else begin
                        state_d = EJECT;
                        timer_d = T_EJECT;
                    end
                end else if (timer_q == T_ONE) begin
                    // Coin not confirmed: remaining is kept so the same coin is retried.
                    state_d = FAULT;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            FAULT: begin
                if (refill) begin
                    if (remaining_q != 2'd0) begin
                        state_d = EJECT;
                        timer_d = T_EJECT;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            if (pend_valid_q) begin
                consume      = 1'b1;
                state_d      = VEND;
                timer_d      = T_VEND;
                remaining_d  = pend_code_q;
                pend_valid_d = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end

        // A slot freed by this cycle's launch can take a new request without overflowing.
        if (dispense && !take_direct) begin
            if (!pend_valid_q || consume) begin
                pend_valid_d = 1'b1;
                pend_code_d  = change;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            remaining_q  <= 2'd0;
            pend_valid_q <= 1'b0;
            pend_code_q  <= 2'd0;
            ovf_q        <= 1'b0;
            hopper_q     <= H_INIT;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            remaining_q  <= remaining_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            ovf_q        <= ovf_d;
            hopper_q     <= hopper_d;
        end
    end

`ifdef DISPENSE_LOG_EN
    logic [15:0] sales_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sales_q <= 16'd0;
        end else if (take_direct || consume) begin
            sales_q <= sales_q + 16'd1;
        end
    end

    assign sales_count = sales_q;
`endif

    assign vend_motor   = (state_q == VEND);
    assign eject        = (state_q == EJECT);
    assign busy         = (state_q != IDLE);
    assign fault        = (state_q == FAULT);
    assign pending_ovf  = ovf_q;
    assign hopper_level = hopper_q;
    assign state_dbg_o  = state_q;

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the coin-accepting vending FSM: consumes its one-cycle `dispense` pulse and 2-bit `change` code, and drives the physical actuators.
- Runs the vend motor for a fixed time, then ejects change one nickel at a time, confirming each coin with the ejector sensor.
- Tracks hopper inventory, buffers one request while busy, and latches faults (empty hopper or missing coin) until a refill.

Parameters:
- VEND_CYCLES, 4, cycles `vend_motor` is held high per sale.
- EJECT_CYCLES, 2, width in cycles of each `eject` pulse.
- ACK_TIMEOUT, 8, max cycles in WAIT_ACK waiting for `coin_seen`.
- HOPPER_INIT, 16, nickel count loaded at reset and on refill.
- CNT_W, 8, width of `hopper_level`.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- dispense  input  1  sale request, sampled each posedge.
- change  input  2  change owed in nickels (0-3), valid with `dispense`.
- coin_seen  input  1  ejector sensor, one coin passed.
- refill  input  1  hopper restocked; sampled each posedge.
- vend_motor  output  1  item motor drive.
- eject  output  1  nickel ejector drive.
- busy  output  1  high whenever state != IDLE.
- fault  output  1  high in FAULT.
- pending_ovf  output  1  sticky flag: a request was dropped.
- hopper_level  output  CNT_W  nickels remaining.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset, async, mid-operation included:
  - state=IDLE; all outputs 0 except `hopper_level`=HOPPER_INIT.
  - Pending buffer cleared; `pending_ovf` cleared.
- States: IDLE, VEND, EJECT, WAIT_ACK, FAULT. Register `remaining` (2 bits), one-entry pending buffer (valid + 2-bit code).
- IDLE: `dispense`=1 -> VEND next cycle; remaining<=change; timer<=VEND_CYCLES. Latency: `vend_motor` and `busy` rise 1 cycle after `dispense` is sampled.
- VEND: `vend_motor`=1 for exactly VEND_CYCLES cycles. Then:
  - remaining==0 -> complete.
  - hopper_level==0 -> FAULT.
  - otherwise -> EJECT.
- EJECT: `eject`=1 for exactly EJECT_CYCLES cycles, then WAIT_ACK with timer<=ACK_TIMEOUT.
- WAIT_ACK:
  - `coin_seen` is sampled only in this state; pulses in other states are ignored.
  - On `coin_seen`: remaining-1 and hopper_level-1 (saturates at 0). Then:
    - remaining now 0 -> complete.
    - else hopper_level now 0 -> FAULT.
    - else -> EJECT.
  - Timer expiry with no `coin_seen` -> FAULT; remaining is unchanged and the coin is retried.
- FAULT:
  - Outputs: `vend_motor`=`eject`=0; `fault`=1; `busy`=1.
  - `refill` -> hopper_level<=HOPPER_INIT and `fault` clears next cycle.
  - Exit: remaining>0 -> EJECT, else -> complete.
- `refill` in any other state: reload hopper_level only; no state change.
- Complete:
  - Pending valid -> VEND directly with pending code; pending cleared; `busy` stays high.
  - Otherwise -> IDLE.
- Pending buffer:
  - `dispense` while state!=IDLE and buffer empty -> stored.
  - Buffer full -> request dropped; `pending_ovf`<=1, sticky until rst.
  - Same cycle as complete-with-pending plus a new `dispense`: old entry consumed, new one stored, no overflow.
- `dispense` with change==0 -> vend only, no eject.

Optional Feature:
- Macro: DISPENSE_LOG_EN.
- Defined:
  - Adds output `sales_count` [15:0], reset 0.
  - Increments on every entry to VEND; wraps 65535->0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset; `dispense`=1, `change`=00 at cycle 0 -> `vend_motor`=1 cycles 1-4; `busy` falls after cycle 4; `eject` never high; hopper_level=16.
- `dispense`, `change`=11; `coin_seen` pulsed 2 cycles after each `eject` falls -> 3 `eject` pulses of 2 cycles each; hopper_level 16->13; `busy` low after third ack.
- `change`=01, `coin_seen` never -> `fault`=1 after 8 WAIT_ACK cycles; `refill` pulse -> `fault` clears, `eject` retried; ack -> hopper_level=15.
- Three `dispense` pulses on consecutive cycles (`change` 00, 01, 10) -> first served, second queued and served with 1 `eject`, third dropped; `pending_ovf`=1.
- HOPPER_INIT=2, `change`=11, all acks given -> 2 coins ejected, then `fault`=1 with remaining=1; `refill` -> third coin ejected; hopper_level=1.
- `rst` asserted during EJECT -> `eject`, `vend_motor`, `busy`, `fault` drop to 0 immediately; hopper_level=16; `sales_count`=0 with DISPENSE_LOG_EN.
